// File: rtl/mlaccel_qpi_host.sv
// QPI initiator for the ML accelerator's quad-SPI slave port: command byte, then
// write bytes or a dummy turnaround followed by read bytes, with valid/ready byte streams.
module mlaccel_qpi_host #(
    parameter int CLKDIV   = 1,
    parameter int DUMMY    = 4,
    parameter int CSB_IDLE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic        rd,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        qpi_csb,
    output logic        qpi_clk,
    output logic [3:0]  qpi_do,
    output logic        qpi_oe,
    input  logic [3:0]  qpi_di,
    input  logic        qpi_rdy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAITRDY,
        S_CMD,
        S_WDATA,
        S_TURN,
        S_RDATA,
        S_FINISH,
        S_GAP
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLKDIV - 1);
    localparam logic [15:0] DUM_LAST = 16'(DUMMY - 1);
    localparam logic [15:0] GAP_LAST = (CSB_IDLE > 1) ? 16'(CSB_IDLE - 1) : 16'd0;

    state_t      state_q, state_d;
    logic        csb_q, csb_d;
    logic        clk_q, clk_d;
    logic        oe_q, oe_d;
    logic [3:0]  do_q, do_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        rd_q, rd_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic        nib_q, nib_d;
    logic        need_q, need_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] dum_q, dum_d;

    logic run;
    logic tick;
    logic rise;
    logic fall;

    // The nibble engine free-runs in the shifting states; a pending write byte or an
    // unconsumed read byte freezes it with qpi_clk low at the byte boundary.
    assign run = (state_q == S_CMD) || (state_q == S_TURN)
              || ((state_q == S_WDATA) && !need_q)
              || ((state_q == S_RDATA) && !(rd_valid_q && !clk_q && !nib_q));
    assign tick = (div_q == DIV_LAST);
    assign rise = run && tick && !clk_q;
    assign fall = run && tick && clk_q;

    assign wr_ready = (state_q == S_WDATA) && need_q && wr_valid;

    always_comb begin
        state_d    = state_q;
        csb_d      = csb_q;
        clk_d      = clk_q;
        oe_d       = oe_q;
        do_d       = do_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        cmd_d      = cmd_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        nib_d      = nib_q;
        need_d     = need_q;
        byte_d     = byte_q;
        dum_d      = dum_q;

        if (run) begin
            if (tick) begin
                div_d = 16'd0;
                clk_d = ~clk_q;
            end else begin
                div_d = div_q + 16'd1;
            end
        end

        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    cmd_d   = cmd;
                    rd_d    = rd;
                    cnt_d   = len;
                    busy_d  = 1'b1;
                    state_d = S_WAITRDY;
                end
            end
            S_WAITRDY: begin
                if (qpi_rdy) begin
                    csb_d   = 1'b0;
                    oe_d    = 1'b1;
                    do_d    = cmd_q[7:4];
                    clk_d   = 1'b0;
                    div_d   = 16'd0;
                    nib_d   = 1'b0;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (fall) begin
                    if (!nib_q) begin
                        nib_d = 1'b1;
                        do_d  = cmd_q[3:0];
                    end else begin
                        nib_d = 1'b0;
                        if (cnt_q == 16'd0) begin
                            state_d = S_FINISH;
                        end else if (!rd_q) begin
                            need_d  = 1'b1;
                            state_d = S_WDATA;
                        end else begin
                            oe_d    = 1'b0;
                            do_d    = 4'h0;
                            dum_d   = 16'd0;
                            state_d = S_TURN;
                        end
                    end
                end
            end
            S_WDATA: begin
                if (need_q) begin
                    if (wr_valid) begin
                        byte_d = wr_data;
                        do_d   = wr_data[7:4];
                        need_d = 1'b0;
                    end
                end else if (fall) begin
                    if (!nib_q) begin
                        nib_d = 1'b1;
                        do_d  = byte_q[3:0];
                    end else begin
                        nib_d = 1'b0;
                        cnt_d = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = S_FINISH;
                        end else begin
                            need_d = 1'b1;
                        end
                    end
                end
            end
            S_TURN: begin
                if (fall) begin
                    if (dum_q == DUM_LAST) begin
                        state_d = S_RDATA;
                    end else begin
                        dum_d = dum_q + 16'd1;
                    end
                end
            end
            S_RDATA: begin
                // Input is captured on the cycle that drives qpi_clk high.
                if (rise) begin
                    if (!nib_q) begin
                        byte_d = {qpi_di, byte_q[3:0]};
                    end else begin
                        rd_data_d  = {byte_q[7:4], qpi_di};
                        rd_valid_d = 1'b1;
                    end
                end
                if (fall) begin
                    if (!nib_q) begin
                        nib_d = 1'b1;
                    end else begin
                        nib_d = 1'b0;
                        cnt_d = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = S_FINISH;
                        end
                    end
                end
            end
            S_FINISH: begin
                if (div_q == DIV_LAST) begin
                    csb_d   = 1'b1;
                    oe_d    = 1'b0;
                    do_d    = 4'h0;
                    done_d  = 1'b1;
                    div_d   = 16'd0;
                    state_d = S_GAP;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            S_GAP: begin
                if (div_q >= GAP_LAST) begin
                    busy_d  = 1'b0;
                    div_d   = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            csb_q      <= 1'b1;
            clk_q      <= 1'b0;
            oe_q       <= 1'b0;
            do_q       <= 4'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
            cmd_q      <= 8'h00;
            rd_q       <= 1'b0;
            cnt_q      <= 16'd0;
            div_q      <= 16'd0;
            nib_q      <= 1'b0;
            need_q     <= 1'b0;
            byte_q     <= 8'h00;
            dum_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            csb_q      <= csb_d;
            clk_q      <= clk_d;
            oe_q       <= oe_d;
            do_q       <= do_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            cmd_q      <= cmd_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            nib_q      <= nib_d;
            need_q     <= need_d;
            byte_q     <= byte_d;
            dum_q      <= dum_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign qpi_csb  = csb_q;
    assign qpi_clk  = clk_q;
    assign qpi_do   = do_q;
    assign qpi_oe   = oe_q;

endmodule

// File: tb/tb_mlaccel_qpi_host.sv
// Directed bench for mlaccel_qpi_host: write, read, backpressure, write stall,
// responder-not-ready and asynchronous abort, with a nibble-level bus monitor.
module tb_mlaccel_qpi_host;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic        rd = 1'b0;
    logic [15:0] len = 16'd0;
    logic        busy;
    logic        done;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic        qpi_csb;
    logic        qpi_clk;
    logic [3:0]  qpi_do;
    logic        qpi_oe;
    logic [3:0]  qpi_di;
    logic        qpi_rdy = 1'b1;

    mlaccel_qpi_host #(.CLKDIV(1), .DUMMY(4), .CSB_IDLE(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .cmd      (cmd),
        .rd       (rd),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .qpi_csb  (qpi_csb),
        .qpi_clk  (qpi_clk),
        .qpi_do   (qpi_do),
        .qpi_oe   (qpi_oe),
        .qpi_di   (qpi_di),
        .qpi_rdy  (qpi_rdy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Bus monitor state, only written by the monitor process.
    int         rises = 0;
    logic       prev_clk = 1'b0;
    int         done_cnt = 0;
    int         wr_pulses = 0;
    logic [3:0] nibs[$];
    logic       fall_oe[$];
    logic [7:0] rbytes[$];

    // Per-transaction baselines, only written by the main process.
    int b_rises = 0;
    int b_nibs = 0;
    int b_falls = 0;
    int b_bytes = 0;
    int b_done = 0;
    int b_wrp = 0;

    logic [3:0] rtab [8];
    int         rn = 0;
    logic [7:0] wtab [4];

    // Responder: data nibbles follow the command and four dummy clocks.
    assign qpi_di = ((rises - b_rises) >= 6 && (rises - b_rises - 6) < rn)
                    ? rtab[rises - b_rises - 6] : 4'h0;

    always @(negedge clock) begin
        if (qpi_clk && !prev_clk) begin
            rises++;
            if (qpi_oe) nibs.push_back(qpi_do);
        end
        if (!qpi_clk && prev_clk) fall_oe.push_back(qpi_oe);
        prev_clk = qpi_clk;
        if (done) done_cnt++;
        if (wr_ready) wr_pulses++;
        if (rd_valid && rd_ready) rbytes.push_back(rd_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        b_rises = rises;
        b_nibs  = nibs.size();
        b_falls = fall_oe.size();
        b_bytes = rbytes.size();
        b_done  = done_cnt;
        b_wrp   = wr_pulses;
    endtask

    task automatic chk_nibs(input string tag, input int n, input logic [23:0] e);
        chk({tag, "_ncnt"}, nibs.size() - b_nibs, n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_nib%0d", tag, i), nibs[b_nibs + i], e[4*(n-1-i) +: 4]);
        end
    endtask

    task automatic chk_bytes(input string tag, input int n, input logic [23:0] e);
        chk({tag, "_bcnt"}, rbytes.size() - b_bytes, n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), rbytes[b_bytes + i], e[8*(n-1-i) +: 8]);
        end
    endtask

    task automatic go(input logic [7:0] c, input logic r, input logic [15:0] n);
        @(posedge clock); #1;
        cmd = c; rd = r; len = n; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int gap);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 2000) begin
            @(negedge clock);
            t++;
        end
        chk("done_seen", done, 1);
        gap = 0;
        while (busy === 1'b1 && gap < 50) begin
            @(negedge clock);
            gap++;
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    // Supplies wtab[0..n-1]; with stall>0, wr_valid drops for that many cycles after byte 0.
    task automatic feed(input int n, input int stall);
        int t;
        int s1;
        int s2;
        wr_data = wtab[0];
        wr_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            t = 0;
            do begin
                @(negedge clock);
                t++;
            end while (wr_ready !== 1'b1 && t < 1000);
            chk($sformatf("wr_acc%0d", i), wr_ready, 1);
            @(posedge clock); #1;
            if (i + 1 < n) begin
                if (i == 0 && stall > 0) begin
                    wr_valid = 1'b0;
                    repeat (6) @(posedge clock);
                    #1;
                    s1 = rises - b_rises;
                    repeat (stall - 6) @(posedge clock);
                    #1;
                    s2 = rises - b_rises;
                    chk("stall_snap", s1, 4);
                    chk("stall_rises", s2, 4);
                    chk("stall_clk", qpi_clk, 0);
                    chk("stall_csb", qpi_csb, 0);
                end
                wr_data = wtab[i + 1];
                wr_valid = 1'b1;
            end else begin
                wr_valid = 1'b0;
            end
        end
    endtask

    initial begin
        int gap;
        int bad;
        int t;

        #2 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_csb", qpi_csb, 1);
        chk("rst_clk", qpi_clk, 0);
        chk("rst_oe", qpi_oe, 0);
        chk("rst_do", qpi_do, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrr", wr_ready, 0);
        chk("rst_rdv", rd_valid, 0);
        chk("rst_rdd", rd_data, 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Write 0x5A, bytes 0x12 0x34, always valid
        mark();
        wtab[0] = 8'h12; wtab[1] = 8'h34;
        go(8'h5A, 1'b0, 16'd2);
        feed(2, 0);
        wait_done(gap);
        $display("write cmd=5a len=2 rises=%0d gap=%0d", rises - b_rises, gap);
        chk_nibs("wr", 6, 24'h5A1234);
        chk("wr_rises", rises - b_rises, 6);
        chk("wr_pulses", wr_pulses - b_wrp, 2);
        chk("wr_done", done_cnt - b_done, 1);
        chk("wr_gap", gap, 2);

        // Read 0x03, two bytes after four dummy clocks
        mark();
        rtab[0] = 4'hC; rtab[1] = 4'h3; rtab[2] = 4'h7; rtab[3] = 4'hE; rn = 4;
        rd_ready = 1'b1;
        go(8'h03, 1'b1, 16'd2);
        wait_done(gap);
        $display("read cmd=03 len=2 rises=%0d", rises - b_rises);
        chk_nibs("rdc", 2, 24'h000003);
        chk("rd_rises", rises - b_rises, 10);
        chk("rd_oe_cmd", fall_oe[b_falls], 1);
        chk("rd_oe_turn", fall_oe[b_falls + 1], 0);
        chk_bytes("rd", 2, 24'h00C37E);
        chk("rd_done", done_cnt - b_done, 1);

        // Read with the consumer stalled after the first byte
        mark();
        rtab[0] = 4'hA; rtab[1] = 4'h5; rtab[2] = 4'h3; rtab[3] = 4'hC;
        rtab[4] = 4'hF; rtab[5] = 4'h0; rn = 6;
        rd_ready = 1'b0;
        go(8'h0B, 1'b1, 16'd3);
        t = 0;
        while (rd_valid !== 1'b1 && t < 500) begin
            @(negedge clock);
            t++;
        end
        chk("bp_first", rd_valid, 1);
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (qpi_clk !== 1'b0 || qpi_csb !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 8'hA5) bad++;
        end
        chk("bp_hold", bad, 0);
        chk("bp_data", rd_data, 8'hA5);
        @(posedge clock); #1;
        rd_ready = 1'b1;
        wait_done(gap);
        $display("read backpressure cmd=0b len=3 rises=%0d", rises - b_rises);
        chk_bytes("bp", 3, 24'hA53CF0);
        chk("bp_rises", rises - b_rises, 12);

        // Write with a 10-cycle wr_valid gap between bytes
        mark();
        wtab[0] = 8'h9C; wtab[1] = 8'h4B;
        go(8'h02, 1'b0, 16'd2);
        feed(2, 10);
        wait_done(gap);
        $display("write underflow cmd=02 len=2 rises=%0d", rises - b_rises);
        chk_nibs("uf", 6, 24'h029C4B);
        chk("uf_pulses", wr_pulses - b_wrp, 2);

        // Responder not ready for 7 cycles, command only
        mark();
        qpi_rdy = 1'b0;
        go(8'h9F, 1'b0, 16'd0);
        bad = 0;
        repeat (7) begin
            @(negedge clock);
            if (qpi_csb !== 1'b1 || busy !== 1'b1) bad++;
        end
        chk("rdy_wait", bad, 0);
        @(posedge clock); #1;
        qpi_rdy = 1'b1;
        wait_done(gap);
        $display("rdy-late cmd=9f len=0 rises=%0d", rises - b_rises);
        chk_nibs("rdy", 2, 24'h00009F);
        chk("rdy_rises", rises - b_rises, 2);
        chk("rdy_done", done_cnt - b_done, 1);

        // Asynchronous reset while shifting write data
        mark();
        wr_data = 8'h66;
        wr_valid = 1'b1;
        go(8'h38, 1'b0, 16'd4);
        t = 0;
        while ((rises - b_rises) < 4 && t < 200) begin
            @(posedge clock); #1;
            t++;
        end
        chk("ar_pre_csb", qpi_csb, 0);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        $display("async reset mid-write csb=%0b clk=%0b oe=%0b busy=%0b", qpi_csb, qpi_clk, qpi_oe, busy);
        chk("ar_csb", qpi_csb, 1);
        chk("ar_clk", qpi_clk, 0);
        chk("ar_oe", qpi_oe, 0);
        chk("ar_busy", busy, 0);
        chk("ar_wrr", wr_ready, 0);
        wr_valid = 1'b0;
        @(posedge clock);
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Fresh write after the abort
        mark();
        wtab[0] = 8'hE7;
        go(8'h11, 1'b0, 16'd1);
        feed(1, 0);
        wait_done(gap);
        $display("write after reset cmd=11 len=1 rises=%0d", rises - b_rises);
        chk_nibs("post", 4, 24'h0011E7);
        chk("post_done", done_cnt - b_done, 1);
        chk("post_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mlaccel_qpi_host.md
Name: mlaccel_qpi_host

Overview:
- QPI initiator that drives the ML accelerator's quad-SPI slave port (csb, clk, io0..io3, rdy) from the control side.
- Turns a transaction request into QPI bus activity: command byte, then write bytes or dummy nibbles plus read bytes.
- Byte streams toward the requester use valid/ready handshakes.
- Sits between the control SoC bus bridge and the pad-level tristate buffers; the tristates live outside this block.

Parameters:
- CLKDIV, 1: qpi_clk half-period in clock cycles (>=1).
- DUMMY, 4: turnaround nibble clocks (io released) between command and read data (>=1).
- CSB_IDLE, 2: minimum clock cycles qpi_csb stays high between transactions.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request pulse; accepted only when busy=0
- cmd  in  8  command byte
- rd  in  1  1=read transaction, 0=write transaction
- len  in  16  data byte count; 0 = command only
- busy  out  1  transaction in progress, including the CSB_IDLE gap
- done  out  1  one-cycle pulse on the cycle qpi_csb rises
- wr_data  in  8  write byte
- wr_valid  in  1  write byte available
- wr_ready  out  1  write byte accepted this cycle
- rd_data  out  8  read byte
- rd_valid  out  1  read byte held, valid until consumed
- rd_ready  in  1  consumer accepts rd_data
- qpi_csb  out  1  chip select, active low
- qpi_clk  out  1  QPI clock, idle low (mode 0)
- qpi_do  out  4  io3..io0 output value
- qpi_oe  out  1  io output enable
- qpi_di  in  4  io3..io0 sampled input, already synchronised externally
- qpi_rdy  in  1  responder ready

Behaviour:
- Reset values (asynchronous): qpi_csb=1, qpi_clk=0, qpi_oe=0, qpi_do=0, busy=0, done=0, wr_ready=0, rd_valid=0, rd_data=0. The FSM goes to IDLE.
- Reset mid-transaction aborts immediately. Nothing is preserved.
- States: IDLE, WAITRDY, CMD, WDATA, TURN, RDATA, FINISH, GAP.
- IDLE: on start, latch cmd/rd/len, set busy=1 next cycle, go to WAITRDY. start while busy=1 is ignored.
- WAITRDY: hold csb high until qpi_rdy=1, then drive csb=0, oe=1, do=cmd[7:4], go to CMD.
- Nibble timing:
  - The nibble is set up while qpi_clk=0.
  - qpi_clk goes high after CLKDIV cycles and low after another CLKDIV cycles, so one nibble = 2*CLKDIV cycles.
  - The next nibble's do changes on the same cycle qpi_clk falls.
  - Order is high nibble first, then low.
- CMD: 2 nibbles. Next state:
  - len=0 -> FINISH
  - rd=0 -> WDATA
  - rd=1 -> TURN
- WDATA:
  - At each byte boundary with qpi_clk=0: if wr_valid=1, assert wr_ready for exactly that cycle, load wr_data, and clock out 2 nibbles.
  - If wr_valid=0, stall with qpi_clk low and csb low (no clock edges).
  - After len bytes -> FINISH.
- TURN: oe=0 on the first cycle, then DUMMY full qpi_clk periods with no sampling. Then -> RDATA.
- RDATA:
  - qpi_di is sampled on the clock cycle in which qpi_clk is driven 0->1. First sample = high nibble.
  - After the 2nd sample, rd_data is loaded and rd_valid=1 from the next cycle.
  - rd_valid stays 1, and rd_data stays stable, until a cycle with rd_ready=1.
  - The host starts no further read byte while rd_valid=1 (clk held low), so there is no overflow. This is a one-byte buffer.
  - rd_valid and rd_ready in the same cycle as the next load is impossible by construction.
  - After len bytes -> FINISH without waiting for the final consume.
- FINISH: hold clk low for CLKDIV cycles, then csb=1, oe=0, done=1 for one cycle -> GAP.
- GAP: CSB_IDLE cycles with csb=1, then busy=0 -> IDLE. A start arriving on the cycle busy falls is accepted next cycle (busy is sampled).
- len counts down in a 16-bit counter. len=65535 is legal with no wrap.
- qpi_rdy is checked only in WAITRDY. A drop mid-transaction is ignored.

Test Plan:
- Write, CLKDIV=1: cmd=0x5A, len=2, wr bytes 0x12,0x34 always valid.
  - Expected: csb low for 12 cycles of qpi_clk activity.
  - Nibbles at rising edges: 5,A,1,2,3,4.
  - Two wr_ready pulses, done once, busy low 2 cycles after csb rises.
- Read, DUMMY=4: cmd=0x03, len=2, responder drives 0xC,0x3,0x7,0xE.
  - Expected: oe=0 from the turnaround start.
  - 4 clocks without capture, rd_data 0xC3 then 0x7E.
- Backpressure: read len=3 with rd_ready=0 for 20 cycles after the first byte.
  - Expected: qpi_clk frozen low, csb low, rd_data=first byte held.
  - Resumes when rd_ready=1. All 3 bytes are correct and in order.
- Write underflow: wr_valid low for 10 cycles between bytes.
  - Expected: no qpi_clk edges during the stall, byte order preserved.
- qpi_rdy=0 at start, raised after 7 cycles.
  - Expected: csb stays high until rdy, then the transaction proceeds. len=0 gives exactly 2 nibbles then done.
- Async reset asserted mid-WDATA (non-clock-aligned).
  - Expected: csb=1, clk=0, oe=0, busy=0 immediately. A new start after release works normally.
